// File: rtl/matrix_order_arbiter.sv
// matrix_order_arbiter: round-robin owner of the shared 5x5 ordering unit; optional watchdog under ORDER_TIMEOUT_EN.
// Latency: req to gnt/ord_en 1 cycle; ord_is_ordered rise to ord_en fall and fall to done, 1 cycle each.
// Backpressure: losing or late requesters simply wait in IDLE; a held req is re-arbitrated after done.
module matrix_order_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   r_in,
    input  logic [3*NUM_REQ-1:0]   c_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [1:0]             sel,
    output logic                   busy,
    output logic [2:0]             ord_r,
    output logic [2:0]             ord_c,
    output logic                   ord_en,
    input  logic                   ord_is_ordered
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_d, done_d, err_d;
    logic [1:0]           sel_d;
    logic                 busy_d, ord_en_d;
    logic [2:0]           ord_r_d, ord_c_d;

    logic [3:0]           req_pad;
    logic [11:0]          r_pad, c_pad;
    logic [2:0]           scan_idx;
    logic                 win_found;
    logic [1:0]           win_idx;
    logic [2:0]           win_r, win_c;
    logic                 win_legal;
    logic [NUM_REQ-1:0]   win_oh, sel_oh;
    logic                 tmo_hit;

    assign req_pad = 4'(req);
    assign r_pad   = 12'(r_in);
    assign c_pad   = 12'(c_in);

    // First requester at or after the pointer, wrapping at NUM_REQ (not a power of two in general).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + 3'(k);
            if (scan_idx >= 3'(NUM_REQ))
                scan_idx = scan_idx - 3'(NUM_REQ);
            if (!win_found && req_pad[scan_idx[1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[1:0];
            end
        end
    end

    assign win_r     = r_pad[4'(win_idx) * 4'd3 +: 3];
    assign win_c     = c_pad[4'(win_idx) * 4'd3 +: 3];
    assign win_legal = (win_r >= 3'd1) && (win_r <= 3'd5) &&
                       (win_c >= 3'd1) && (win_c <= 3'd5);
    assign win_oh    = NUM_REQ'(4'b0001 << win_idx);
    assign sel_oh    = NUM_REQ'(4'b0001 << sel);

`ifdef ORDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts cycles spent in the current RUN/REL visit; every state entry restarts it.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        if ((state_d != state_q) || (state_d == IDLE))
            tmo_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_cfg;

    assign tmo_hit    = 1'b0;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt;
        done_d   = '0;
        err_d    = '0;
        sel_d    = sel;
        ord_r_d  = ord_r;
        ord_c_d  = ord_c;
        ord_en_d = ord_en;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ptr_d   = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
                    sel_d   = win_idx;
                    ord_r_d = win_r;
                    ord_c_d = win_c;
                    if (win_legal) begin
                        gnt_d    = win_oh;
                        ord_en_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        err_d = win_oh;
                    end
                end
            end
            RUN: begin
                if (ord_is_ordered) begin
                    ord_en_d = 1'b0;
                    state_d  = REL;
                end
            end
            REL: begin
                // Wait for the unit to drop its flag so the next run cannot see a stale completion.
                if (!ord_is_ordered) begin
                    done_d  = sel_oh;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d    = '0;
                ord_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Watchdog only fires when no regular transition is already happening this cycle.
        if (tmo_hit && (state_d == state_q)) begin
            err_d    = sel_oh;
            gnt_d    = '0;
            ord_en_d = 1'b0;
            state_d  = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            ord_r   <= '0;
            ord_c   <= '0;
            ord_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            done    <= done_d;
            err     <= err_d;
            sel     <= sel_d;
            busy    <= busy_d;
            ord_r   <= ord_r_d;
            ord_c   <= ord_c_d;
            ord_en  <= ord_en_d;
        end
    end

endmodule

// File: doc/matrix_order_arbiter.md
# matrix_order_arbiter

Round-robin arbiter and sequencer for the shared 5x5 matrix-ordering unit. Up to four requesters (manual entry, random generator, operand loaders) request reordering of their flat data into an r x c grid. The block grants one requester at a time and drives the ordering unit's `r`, `c` and `en`. It tracks the unit's `isOrdered` flag through a full run and release cycle, then returns a one-cycle `done` pulse. The data-path multiplexing of the 25 input words is external and steered by `sel`.

## Interface

Parameters:
- `NUM_REQ`, 2: number of requesters; legal range 2..4.
- `TIMEOUT_CYCLES`, 64: watchdog limit in cycles; used only when `ORDER_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level.
- `r_in`  in  3*NUM_REQ  row count per requester; requester i uses bits [3i+2:3i].
- `c_in`  in  3*NUM_REQ  column count per requester; same packing as `r_in`.
- `gnt`  out  NUM_REQ  one-hot grant; held for the whole transaction.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `err`  out  NUM_REQ  one-cycle rejection or timeout pulse.
- `sel`  out  2  index of the granted requester, for the external data mux.
- `busy`  out  1  high in any state other than IDLE.
- `ord_r`  out  3  row count driven to the ordering unit.
- `ord_c`  out  3  column count driven to the ordering unit.
- `ord_en`  out  1  enable driven to the ordering unit.
- `ord_is_ordered`  in  1  completion flag returned by the ordering unit.

## Operation

- All outputs are registered. Reset value of every output is 0. The round-robin pointer resets to 0.
- State IDLE:
  - When any `req` is high, the winner is the first requester at or after the pointer, scanning upward with wrap.
  - The winner's r/c are latched into `ord_r`/`ord_c`, and `sel` is set to the winner's index.
  - The pointer moves to (winner+1) mod NUM_REQ.
- Validation of the latched r/c:
  - Legal values are 1..5 for both r and c.
  - If either is illegal: `err[winner]` pulses for one cycle, no grant is issued, `ord_en` stays 0, and the state stays IDLE.
  - If both are legal: `gnt[winner]`=1, `ord_en`=1, and the state moves to RUN.
- State RUN: hold `ord_en`=1. When `ord_is_ordered`=1 is sampled, drive `ord_en`=0 and move to REL.
- State REL:
  - Hold `ord_en`=0 until `ord_is_ordered`=0 is sampled.
  - Then pulse `done[winner]` for one cycle, clear `gnt` on the same edge, and return to IDLE.
- `ord_r`, `ord_c` and `sel` hold their values from grant until the next grant.
- Requester drops after grant: `req` deasserting during RUN/REL is ignored and the transaction completes normally.
- Request still high after `done`: a `req` still high in the cycle after `done` is treated as a new request. Round-robin gives the other requesters priority first.
- Simultaneous requests: exactly one grant is issued; losers wait with no error.
- `ord_is_ordered` already high on entry to RUN (stale flag): it is treated as completion. The REL drain guarantees this cannot happen in normal operation.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs at 0. No `done` or `err` pulse is produced.

## Timing

- Sampled `req` to `gnt`/`ord_en` high: 1 cycle.
- `ord_is_ordered` rising to `ord_en` falling: 1 cycle.
- `ord_is_ordered` falling to `done` pulse: 1 cycle.
- With the 25-position ordering unit, `req` sampled at edge 0 gives:
  - `ord_is_ordered` high after edge 27;
  - `ord_en` low after edge 28;
  - `done` high for the cycle after edge 30.
- Back-to-back transactions: minimum gap of 1 IDLE cycle between `done` and the next `gnt`.
- `err` for illegal r/c: 1 cycle after the request is sampled.

## Configuration

- `ORDER_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN and REL and resets on every state entry.
  - When the counter reaches `TIMEOUT_CYCLES`, the block pulses `err[winner]`, clears `gnt`, drives `ord_en`=0 and returns to IDLE without `done`.
- `ORDER_TIMEOUT_EN` undefined:
  - No counter is built, and the block waits indefinitely in RUN/REL.
  - `TIMEOUT_CYCLES` is unused.

## Test plan

- Single request: `req`=01, r=2, c=3 on requester 0 → `gnt`=01 one cycle later, `ord_r`=2, `ord_c`=3, `ord_en`=1; `done`=01 after 30 cycles; `gnt`=00 on that same edge.
- Contention: `req`=11 held continuously → grants alternate 01, 10, 01 across three transactions, each with its own `done` pulse and no `err`.
- Illegal size: r=0, c=4 on requester 1 → `err`=10 for one cycle; `gnt` and `ord_en` never rise; state stays IDLE.
- Early drop: requester 0 drops `req` 5 cycles after grant → `ord_en` stays high until `ord_is_ordered`; `done`=01 still fires.
- Mid-run reset: `reset_n` low 10 cycles into RUN → `gnt`, `ord_en`, `busy`, `sel`, `ord_r`, `ord_c` all 0 immediately; no `done`; the next request is granted to requester 0.
- With `ORDER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: `ord_is_ordered` tied 0 → `err`=01 16 cycles after grant, `ord_en`=0, return to IDLE.
